// File: rtl/encoder83_scan.sv
// encoder83_scan: debounced 8-to-3 priority encoder with a valid/acknowledge report handshake.
// Build macro ENCODER83_SCAN_MULTI_EN enables the o_multi flag; without it o_multi is tied to 0.
module encoder83_scan #(
    parameter int unsigned DEB_CNT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_y,
    input  logic       i_opt,
    input  logic       i_ack,
    output logic [2:0] o_sel,
    output logic       o_valid,
    output logic       o_multi,
    output logic [1:0] o_state
);

    // Handshake: o_valid rises together with o_sel/o_multi and all three hold unchanged until
    // i_ack is sampled high; o_valid falls on that edge. i_ack while o_valid is low is ignored.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEB    = 2'd1,
        ST_REPORT = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEB_CNT - 1);

    logic [7:0] y_meta_q, y_sync_q;
    logic       opt_meta_q, opt_sync_q;
    logic [1:0] prime_q;
    logic       opt_ref_q, opt_ref_d;
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] snap_q, snap_d;
    logic [2:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic [7:0] act, act_v;
    logic       opt_chg;

`ifdef ENCODER83_SCAN_MULTI_EN
    logic       multi_q, multi_d;
`endif

    function automatic logic [2:0] top_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic more_than_one(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    // The synchronizers reset to 0, so their output is meaningless for the first two edges;
    // prime_q masks that window so reset release never produces a spurious detection.
    assign act     = opt_sync_q ? y_sync_q : ~y_sync_q;
    assign act_v   = prime_q[1] ? act : 8'h00;
    assign opt_chg = prime_q[1] && (opt_sync_q != opt_ref_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        opt_ref_d = opt_ref_q;
`ifdef ENCODER83_SCAN_MULTI_EN
        multi_d   = multi_q;
`endif
        if (!prime_q[1]) begin
            opt_ref_d = opt_meta_q;
        end else if (opt_chg && state_q != ST_REPORT) begin
            // A polarity change while reporting waits until the report is acknowledged.
            state_d   = ST_IDLE;
            cnt_d     = 8'd0;
            opt_ref_d = opt_sync_q;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (act_v != 8'h00) begin
                        snap_d  = act_v;
                        cnt_d   = 8'd0;
                        state_d = ST_DEB;
                    end
                end
                ST_DEB: begin
                    if (act_v == 8'h00) begin
                        cnt_d   = 8'd0;
                        state_d = ST_IDLE;
                    end else if (act_v != snap_q) begin
                        snap_d = act_v;
                        cnt_d  = 8'd0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_REPORT;
                        sel_d   = top_index(snap_q);
                        valid_d = 1'b1;
`ifdef ENCODER83_SCAN_MULTI_EN
                        multi_d = more_than_one(snap_q);
`endif
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_REPORT: begin
                    if (i_ack) begin
                        state_d = ST_HOLD;
                        valid_d = 1'b0;
                        cnt_d   = 8'd0;
                    end
                end
                ST_HOLD: begin
                    // Lines must read released for DEB_CNT cycles before a new detection.
                    if (act_v != 8'h00) begin
                        cnt_d = 8'd0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            y_meta_q   <= 8'h00;
            y_sync_q   <= 8'h00;
            opt_meta_q <= 1'b0;
            opt_sync_q <= 1'b0;
            prime_q    <= 2'b00;
            opt_ref_q  <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            snap_q     <= 8'h00;
            sel_q      <= 3'd0;
            valid_q    <= 1'b0;
        end else begin
            y_meta_q   <= i_y;
            y_sync_q   <= y_meta_q;
            opt_meta_q <= i_opt;
            opt_sync_q <= opt_meta_q;
            prime_q    <= {prime_q[0], 1'b1};
            opt_ref_q  <= opt_ref_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
        end
    end

`ifdef ENCODER83_SCAN_MULTI_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            multi_q <= 1'b0;
        end else begin
            multi_q <= multi_d;
        end
    end
    assign o_multi = multi_q;
`else
    assign o_multi = 1'b0;
`endif

    assign o_sel   = sel_q;
    assign o_valid = valid_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_encoder83_scan.sv
// tb_encoder83_scan: vector table, hand-written corner sequences and randomized stimulus
// checked against a run-length reference model of the debounced encoder.
module tb_encoder83_scan;

    localparam int DEB_CNT = 4;
`ifdef ENCODER83_SCAN_MULTI_EN
    localparam logic MULTI_ON = 1'b1;
`else
    localparam logic MULTI_ON = 1'b0;
`endif
    localparam int PH_WAIT = 0;
    localparam int PH_REPORTED = 1;
    localparam int PH_RELEASE = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] y;
    logic       opt;
    logic       ack;
    logic [2:0] sel;
    logic       valid;
    logic       multi;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    encoder83_scan #(.DEB_CNT(DEB_CNT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_y     (y),
        .i_opt   (opt),
        .i_ack   (ack),
        .o_sel   (sel),
        .o_valid (valid),
        .o_multi (multi),
        .o_state (state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] m_y_pipe [2];
    logic       m_opt_pipe [2];
    int         m_fill;
    int         m_phase;
    int         m_run;
    int         m_zero_run;
    logic [7:0] m_prev;
    logic       m_have_opt;
    logic       m_opt_applied;
    logic       m_valid;
    logic [2:0] m_sel;
    logic       m_multi;

    task automatic model_reset();
        m_y_pipe[0] = 8'h00; m_y_pipe[1] = 8'h00;
        m_opt_pipe[0] = 1'b0; m_opt_pipe[1] = 1'b0;
        m_fill = 0; m_phase = PH_WAIT; m_run = 0; m_zero_run = 0;
        m_prev = 8'h00; m_have_opt = 1'b0; m_opt_applied = 1'b0;
        m_valid = 1'b0; m_sel = 3'd0; m_multi = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] yi, input logic oi, input logic ai);
        logic [7:0] a;
        logic       o;
        logic       chg;
        if (m_fill >= 2) begin
            o   = m_opt_pipe[1];
            a   = o ? m_y_pipe[1] : ~m_y_pipe[1];
            chg = m_have_opt && (o != m_opt_applied);
            if (!m_have_opt) begin
                m_have_opt = 1'b1;
                m_opt_applied = o;
            end
            if (chg && m_phase != PH_REPORTED) begin
                m_phase = PH_WAIT; m_run = 0; m_opt_applied = o;
            end else if (m_phase == PH_WAIT) begin
                if (a == 8'h00) m_run = 0;
                else if (m_run > 0 && a == m_prev) m_run++;
                else m_run = 1;
                m_prev = a;
                if (m_run == DEB_CNT + 1) begin
                    m_phase = PH_REPORTED;
                    m_valid = 1'b1;
                    m_sel   = 3'($clog2(int'(a) + 1) - 1);
                    m_multi = MULTI_ON && ($countones(a) > 1);
                end
            end else if (m_phase == PH_REPORTED) begin
                if (ai) begin
                    m_phase = PH_RELEASE; m_valid = 1'b0; m_zero_run = 0;
                end
            end else begin
                if (a == 8'h00) m_zero_run++;
                else m_zero_run = 0;
                if (m_zero_run == DEB_CNT) begin
                    m_phase = PH_WAIT; m_run = 0;
                end
            end
        end
        m_y_pipe[1] = m_y_pipe[0]; m_y_pipe[0] = yi;
        m_opt_pipe[1] = m_opt_pipe[0]; m_opt_pipe[0] = oi;
        if (m_fill < 2) m_fill++;
    endtask

    function automatic logic [1:0] model_state();
        if (m_phase == PH_REPORTED) return 2'd2;
        if (m_phase == PH_RELEASE) return 2'd3;
        return (m_run > 0) ? 2'd1 : 2'd0;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Called at a falling edge: drive, let one rising edge happen, return at the next falling edge.
    task automatic step(input logic [7:0] yi, input logic oi, input logic ai);
        y = yi; opt = oi; ack = ai;
        @(posedge clk);
        if (rst_n) model_edge(yi, oi, ai);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'(m_valid));
        check({tag, "_sel"},   32'(sel),   32'(m_sel));
        check({tag, "_multi"}, 32'(multi), 32'(m_multi));
        check({tag, "_state"}, 32'(state), 32'(model_state()));
    endtask

    typedef struct {
        logic [7:0] y;
        logic       opt;
        logic       ack;
        int         cycles;
        logic       valid;
        logic [2:0] sel;
        logic       multi;
        logic [1:0] state;
    } vec_t;

    vec_t vecs [19];
    int   lat;
    int   vcount;
    logic [7:0] r_y;
    logic       r_opt;
    int         r_len;

    initial begin
        vecs[0]  = '{8'h20, 1'b1, 1'b0, 6,  1'b0, 3'd0, 1'b0, 2'd1};
        vecs[1]  = '{8'h20, 1'b1, 1'b0, 1,  1'b1, 3'd5, 1'b0, 2'd2};
        vecs[2]  = '{8'h00, 1'b1, 1'b0, 3,  1'b1, 3'd5, 1'b0, 2'd2};
        vecs[3]  = '{8'h00, 1'b1, 1'b1, 1,  1'b0, 3'd5, 1'b0, 2'd3};
        vecs[4]  = '{8'h00, 1'b1, 1'b0, 3,  1'b0, 3'd5, 1'b0, 2'd3};
        vecs[5]  = '{8'h00, 1'b1, 1'b0, 1,  1'b0, 3'd5, 1'b0, 2'd0};
        vecs[6]  = '{8'hFF, 1'b0, 1'b0, 4,  1'b0, 3'd5, 1'b0, 2'd0};
        vecs[7]  = '{8'hFE, 1'b0, 1'b0, 6,  1'b0, 3'd5, 1'b0, 2'd1};
        vecs[8]  = '{8'hFE, 1'b0, 1'b0, 1,  1'b1, 3'd0, 1'b0, 2'd2};
        vecs[9]  = '{8'hFF, 1'b0, 1'b1, 1,  1'b0, 3'd0, 1'b0, 2'd3};
        vecs[10] = '{8'hFF, 1'b0, 1'b0, 4,  1'b0, 3'd0, 1'b0, 2'd3};
        vecs[11] = '{8'hFF, 1'b0, 1'b0, 1,  1'b0, 3'd0, 1'b0, 2'd0};
        vecs[12] = '{8'h7F, 1'b0, 1'b0, 7,  1'b1, 3'd7, 1'b0, 2'd2};
        vecs[13] = '{8'h7F, 1'b0, 1'b1, 1,  1'b0, 3'd7, 1'b0, 2'd3};
        vecs[14] = '{8'h7F, 1'b0, 1'b0, 10, 1'b0, 3'd7, 1'b0, 2'd3};
        vecs[15] = '{8'h00, 1'b1, 1'b0, 3,  1'b0, 3'd7, 1'b0, 2'd0};
        vecs[16] = '{8'h12, 1'b1, 1'b0, 7,  1'b1, 3'd4, MULTI_ON, 2'd2};
        vecs[17] = '{8'h00, 1'b1, 1'b1, 1,  1'b0, 3'd4, MULTI_ON, 2'd3};
        vecs[18] = '{8'h00, 1'b1, 1'b0, 5,  1'b0, 3'd4, MULTI_ON, 2'd0};

        // clock/reset
        rst_n = 1'b0; y = 8'h00; opt = 1'b1; ack = 1'b0;
        model_reset();
        #1;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_sel",   32'(sel),   32'd0);
        check("reset_multi", 32'(multi), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(8'h00, 1'b1, 1'b0);

        // table-driven scenarios
        for (int i = 0; i < 19; i++) begin
            for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].y, vecs[i].opt, vecs[i].ack);
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_sel", i),   32'(sel),   32'(vecs[i].sel));
            check($sformatf("vec%0d_multi", i), 32'(multi), 32'(vecs[i].multi));
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].state));
        end

        // bounce 04/00 every 2 cycles, then hold 04
        for (int i = 0; i < 20; i++) begin
            step(((i / 2) % 2 == 0) ? 8'h04 : 8'h00, 1'b1, 1'b0);
            check("bounce_valid_low", 32'(valid), 32'd0);
        end
        lat = 0;
        for (int e = 1; e <= 20; e++) begin
            step(8'h04, 1'b1, 1'b0);
            if (valid === 1'b1) begin
                lat = e;
                break;
            end
        end
        check("bounce_latency", 32'(lat), 32'(DEB_CNT + 3));
        check("bounce_sel", 32'(sel), 32'd2);
        step(8'h04, 1'b1, 1'b1);
        repeat (8) step(8'h00, 1'b1, 1'b0);
        check_model("after_bounce");

        // ack held high: one report only
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            step(8'h08, 1'b1, 1'b1);
            if (valid === 1'b1) vcount++;
        end
        check("ackheld_pulses", 32'(vcount), 32'd1);
        check("ackheld_sel", 32'(sel), 32'd3);
        check("ackheld_state", 32'(state), 32'd3);
        repeat (8) step(8'h00, 1'b1, 1'b0);

        // reset while reporting
        repeat (7) step(8'h20, 1'b1, 1'b0);
        check("prereset_valid", 32'(valid), 32'd1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_abort_valid", 32'(valid), 32'd0);
        check("rst_abort_state", 32'(state), 32'd0);
        check("rst_abort_sel",   32'(sel),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int e = 1; e <= 20; e++) begin
            step(8'h20, 1'b1, 1'b0);
            if (valid === 1'b1) begin
                lat = e;
                break;
            end
        end
        check("rerun_latency", 32'(lat), 32'(DEB_CNT + 3));
        check("rerun_sel", 32'(sel), 32'd5);
        step(8'h20, 1'b1, 1'b1);
        repeat (8) step(8'h00, 1'b1, 1'b0);
        check_model("after_reset_seq");

        // randomized stimulus against the model
        r_opt = 1'b1;
        for (int seg = 0; seg < 120; seg++) begin
            case ($urandom_range(0, 3))
                0:       r_y = 8'h00;
                1:       r_y = 8'h01 << $urandom_range(0, 7);
                2:       r_y = 8'hFF;
                default: r_y = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 9) == 0) r_opt = ~r_opt;
            r_len = $urandom_range(1, 12);
            for (int c = 0; c < r_len; c++) begin
                step(r_y, r_opt, ($urandom_range(0, 3) == 0));
                check_model("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder83_scan.md
ENCODER83_SCAN -- requirements
Module: encoder83_scan

Interface
REQ-001 Parameter DEB_CNT, default 4, range 1..255: the number of consecutive stable cycles required before a code is reported or a release is accepted.
REQ-002 i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 i_y  input  8  asynchronous select lines, one line per code 0..7.
REQ-005 i_opt  input  1  polarity; 1 = lines active-high, 0 = lines active-low; quasi-static.
REQ-006 i_ack  input  1  consumer acknowledge of the reported code.
REQ-007 o_sel  output  3  encoded index of the highest-numbered active line.
REQ-008 o_valid  output  1  the code on o_sel is valid and awaiting i_ack.
REQ-009 o_multi  output  1  more than one line was active in the reported snapshot.

Function
REQ-010 Each bit of i_y and i_opt shall pass through a 2-flop synchronizer before use.
REQ-011 The active vector shall be act = i_opt_sync ? i_y_sync : ~i_y_sync.
REQ-012 The FSM shall have four states: IDLE, DEB, REPORT, HOLD; 8-bit cycle counter cnt; 8-bit snapshot register snap.
REQ-013 IDLE: when act==0, remain in IDLE; when act!=0, set snap=act, cnt=0, and go to DEB.
REQ-014 DEB, act==0: go to IDLE.
REQ-015 DEB, act!=snap and act!=0: set snap=act, cnt=0, and stay in DEB.
REQ-016 DEB, act==snap: increment cnt; when cnt==DEB_CNT-1, go to REPORT.
REQ-017 On the DEB-to-REPORT edge, load o_sel with the index of the highest set bit of snap, load o_multi, and set o_valid=1.
REQ-018 Latency: with i_y stable from its first sampling edge, o_valid shall rise on edge DEB_CNT+3.
REQ-019 REPORT: o_valid, o_sel and o_multi shall hold stable regardless of i_y until i_ack is sampled 1.
REQ-020 On that i_ack edge, the FSM shall go to HOLD and set o_valid=0, so o_valid drops one cycle after i_ack.
REQ-021 i_ack sampled while o_valid==0 shall be ignored; i_ack held high shall complete only one report.
REQ-022 HOLD: cnt shall clear whenever act!=0 and increment whenever act==0.
REQ-023 HOLD: when cnt==DEB_CNT-1 with act==0, go to IDLE; a code shall not be re-reported until released.
REQ-024 A change of i_opt_sync in any state other than REPORT shall force IDLE with cnt=0.
REQ-025 A change of i_opt_sync while in REPORT shall be applied after the acknowledge completes.
REQ-026 o_sel and o_multi shall hold their last values outside REPORT.

Reset
REQ-027 While i_rst_n==0, the block shall asynchronously enter IDLE with cnt=0, snap=0, o_sel=0, o_valid=0, o_multi=0, and synchronizer flops = 0.
REQ-028 Reset asserted in any state, including REPORT, shall abort the pending report with no acknowledge required.
REQ-029 Release from reset shall be synchronous to i_clk, and the first post-reset detection shall obey REQ-018.

Configuration
REQ-030 Macro ENCODER83_SCAN_MULTI_EN: when defined, o_multi shall be registered as (popcount(snap)>1) on the REPORT load.
REQ-031 When ENCODER83_SCAN_MULTI_EN is undefined, o_multi shall be tied to 0, and the port list and all other behaviour shall be unchanged.

Verification
REQ-032 Scenario 1: DEB_CNT=4, i_opt=1, i_y=8'h20 held -> o_valid=1, o_sel=5, o_multi=0 on edge 7.
REQ-033 Scenario 1 continued: i_ack pulse -> o_valid=0 next edge; i_y=0 for 4 cycles -> state IDLE.
REQ-034 Scenario 2: i_opt=0, i_y=8'hFE -> o_sel=0; then i_y=8'h7F after release -> o_sel=7.
REQ-035 Scenario 3: i_opt=1, i_y=8'h12 with MULTI_EN defined -> o_sel=4, o_multi=1; same stimulus without MULTI_EN -> o_multi=0.
REQ-036 Scenario 4: bounce i_y 8'h04/0 every 2 cycles for 20 cycles, then hold 8'h04 -> o_valid stays 0 during bounce, then o_sel=2 rises DEB_CNT+3 edges after the last change.
REQ-037 Scenario 5: i_ack held 1 continuously with i_y=8'h08 held -> exactly one o_valid pulse of 1 cycle and no re-report while i_y stays 8'h08.
REQ-038 Scenario 6: i_rst_n=0 while o_valid=1 -> o_valid=0 immediately; after release with i_y held -> re-report on edge 7.
